// File: rtl/pcm_to_pwm_mc_if.sv
// ---------------------------------------------------------------------------
// pcm_to_pwm_mc_if
//
// Purpose:
//   Sample handshake bundle between the FM/PSG mixer (master) and the
//   multi-channel PCM-to-1-bit modulator (slave). A sample set moves across
//   in the cycle where valid and ready are both high.
//
// Signals:
//   pcm    NCH*DW  packed samples, channel k at bits [k*DW +: DW]
//   valid  1       pcm holds a new sample set (driven by the master)
//   ready  1       modulator shadow buffer is empty (driven by the slave)
//
// Modports:
//   master  drives pcm/valid, observes ready
//   slave   observes pcm/valid, drives ready
// ---------------------------------------------------------------------------
interface pcm_to_pwm_mc_if #(
  parameter int NCH = 2,
  parameter int DW  = 16
);

  logic [NCH*DW-1:0] pcm;
  logic              valid;
  logic              ready;

  modport master (
    output pcm,
    output valid,
    input  ready
  );

  modport slave (
    input  pcm,
    input  valid,
    output ready
  );

endinterface

// File: rtl/pcm_to_pwm_mc.sv
// ---------------------------------------------------------------------------
// pcm_to_pwm_mc
//
// Purpose:
//   Multi-channel PCM-to-1-bit audio modulator. Each channel turns the top
//   CW bits of its PCM sample into a duty value and drives a registered
//   1-bit output, either as plain PWM over a 2^CW-clock period or as a
//   first-order sigma-delta bit stream. New samples arrive through a
//   valid/ready handshake into a shadow buffer and only become active at a
//   period boundary, so a period is never cut short by a duty change.
//
// Parameters:
//   NCH        number of channels
//   DW         PCM sample width per channel
//   CW         modulator resolution; one period lasts 2^CW clocks
//   SIGNED_IN  1 = two's-complement samples, 0 = unsigned samples
//
// Ports:
//   clk             system clock
//   rst             synchronous active-high reset
//   pcm_bus         sample handshake (slave side): pcm, valid, ready
//   mode_i          0 = PWM, 1 = sigma-delta; taken at period boundary only
//   pwm_o           registered 1-bit outputs, one per channel
//   period_start_o  pulse in the cycle the first bit of a period appears
//   underrun_o      pulse after a boundary that found no pending sample
// ---------------------------------------------------------------------------
module pcm_to_pwm_mc #(
  parameter int NCH       = 2,
  parameter int DW        = 16,
  parameter int CW        = 8,
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  pcm_to_pwm_mc_if.slave        pcm_bus,
  input  logic                  mode_i,
  output logic [NCH-1:0]        pwm_o,
  output logic                  period_start_o,
  output logic                  underrun_o
);

  // Midscale duty is silence: half the period high in PWM mode and a
  // 50 % ones density in sigma-delta mode.
  localparam logic [CW-1:0] MIDSCALE = {1'b1, {(CW-1){1'b0}}};

  // ------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------
  logic [CW-1:0]           counter_q,     counter_d;
  logic                    shadowFull_q,  shadowFull_d;
  logic [NCH-1:0][CW-1:0]  shadow_q,      shadow_d;
  logic [NCH-1:0][CW-1:0]  duty_q,        duty_d;
  logic [NCH-1:0][CW-1:0]  acc_q,         acc_d;
  logic                    mode_q,        mode_d;
  logic [NCH-1:0]          pwm_q,         pwm_d;
  logic                    periodStart_q, periodStart_d;
  logic                    underrun_q,    underrun_d;

  // ------------------------------------------------------------------------
  // Combinational helpers
  // ------------------------------------------------------------------------
  logic                    boundary;
  logic                    pcmReady;
  logic                    transfer;
  logic                    modeChange;
  logic [NCH-1:0][CW-1:0]  dutyIn;
  logic [NCH-1:0][CW:0]    sdSum;

  // The last count of a period is where the active duty and mode are
  // swapped, so the very next count (0) already runs with the new values.
  assign boundary = (counter_q == {CW{1'b1}});

  // Ready is forced low while reset is held so no sample can slip into a
  // shadow buffer that is about to be cleared.
  assign pcmReady       = !shadowFull_q && !rst;
  assign pcm_bus.ready  = pcmReady;
  assign transfer       = pcm_bus.valid && pcmReady;

  // The accumulators only restart when the output flavour really changes;
  // re-selecting the same mode keeps the bit stream continuous.
  assign modeChange = boundary && (mode_i != mode_q);

  // Each channel's duty is the top CW bits of its sample. For signed input
  // the MSB is flipped, which maps two's complement onto offset binary
  // (most negative -> 0, zero -> midscale, most positive -> all ones).
  // Lower sample bits are truncated, not rounded.
  always_comb begin
    dutyIn = '0;
    for (int k = 0; k < NCH; k++) begin
      dutyIn[k] = pcm_bus.pcm[k*DW + DW - CW +: CW];
      if (SIGNED_IN) begin
        dutyIn[k][CW-1] = ~dutyIn[k][CW-1];
      end
    end
  end

  // The bits below the duty resolution are intentionally discarded; they
  // are folded into a dummy signal so the truncation reads as deliberate.
  generate
    if (DW > CW) begin : g_truncated
      logic unusedLowBits;
      always_comb begin
        unusedLowBits = 1'b0;
        for (int k = 0; k < NCH; k++) begin
          unusedLowBits = unusedLowBits ^ (^pcm_bus.pcm[k*DW +: DW-CW]);
        end
      end
    end
  endgenerate

  // ------------------------------------------------------------------------
  // Period counter, shadow buffer and active duty/mode.
  // The boundary consumes whatever was in the shadow before this cycle.
  // A transfer is only possible while the shadow is empty, so a transfer
  // in the boundary cycle fills the shadow for the following boundary and
  // never reaches the active duty directly.
  // ------------------------------------------------------------------------
  always_comb begin
    counter_d     = counter_q + 1'b1;
    shadowFull_d  = shadowFull_q;
    shadow_d      = shadow_q;
    duty_d        = duty_q;
    mode_d        = mode_q;
    underrun_d    = boundary && !shadowFull_q;
    periodStart_d = (counter_q == '0);

    if (boundary) begin
      mode_d = mode_i;
      if (shadowFull_q) begin
        duty_d       = shadow_q;
        shadowFull_d = 1'b0;
      end
    end

    if (transfer) begin
      shadow_d     = dutyIn;
      shadowFull_d = 1'b1;
    end
  end

  // ------------------------------------------------------------------------
  // Per-channel modulators.
  // Sigma-delta: the accumulator keeps the low CW bits of acc + duty and the
  // carry out of that sum becomes the output bit, so the carry register of
  // the (CW+1)-bit accumulator is the output flop itself. The accumulators
  // run in PWM mode too; they are cleared when the mode flips, which lines
  // the sigma-delta stream up with the period start.
  // PWM: output is high while the counter is below the duty.
  // ------------------------------------------------------------------------
  always_comb begin
    sdSum = '0;
    acc_d = acc_q;
    pwm_d = '0;
    for (int k = 0; k < NCH; k++) begin
      sdSum[k] = {1'b0, acc_q[k]} + {1'b0, duty_q[k]};
      acc_d[k] = modeChange ? '0 : sdSum[k][CW-1:0];
      pwm_d[k] = mode_q ? sdSum[k][CW] : (counter_q < duty_q[k]);
    end
  end

  // ------------------------------------------------------------------------
  // State registers with synchronous reset. Reset drops any pending shadow
  // sample and returns every channel to midscale silence in PWM mode.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_q     <= '0;
      shadowFull_q  <= 1'b0;
      shadow_q      <= {NCH{MIDSCALE}};
      duty_q        <= {NCH{MIDSCALE}};
      acc_q         <= '0;
      mode_q        <= 1'b0;
      pwm_q         <= '0;
      periodStart_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      counter_q     <= counter_d;
      shadowFull_q  <= shadowFull_d;
      shadow_q      <= shadow_d;
      duty_q        <= duty_d;
      acc_q         <= acc_d;
      mode_q        <= mode_d;
      pwm_q         <= pwm_d;
      periodStart_q <= periodStart_d;
      underrun_q    <= underrun_d;
    end
  end

  assign pwm_o          = pwm_q;
  assign period_start_o = periodStart_q;
  assign underrun_o     = underrun_q;

endmodule

// File: tb/tb_pcm_to_pwm_mc.sv
// ---------------------------------------------------------------------------
// tb_pcm_to_pwm_mc
//
// Purpose:
//   Self-checking bench for pcm_to_pwm_mc with NCH=2, DW=16, CW=8,
//   SIGNED_IN=1. A period-level model predicts every output bit from the
//   position inside the period, the active duty and the active mode; a
//   negedge process compares it with the DUT each cycle. Directed phases
//   additionally count ones per period against hand-computed numbers.
// ---------------------------------------------------------------------------
module tb_pcm_to_pwm_mc;

  localparam int NCH = 2;
  localparam int DW  = 16;
  localparam int CW  = 8;
  localparam int PER = 256;

  logic           clk;
  logic           rst;
  logic           mode;
  wire  [NCH-1:0] pwmW;
  wire            psW;
  wire            urW;

  int compared   = 0;
  int mismatched = 0;

  pcm_to_pwm_mc_if #(.NCH(NCH), .DW(DW)) pcmIf ();

  pcm_to_pwm_mc #(
    .NCH       (NCH),
    .DW        (DW),
    .CW        (CW),
    .SIGNED_IN (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pcm_bus        (pcmIf),
    .mode_i         (mode),
    .pwm_o          (pwmW),
    .period_start_o (psW),
    .underrun_o     (urW)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if the DUT stalls a wait loop.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // ------------------------------------------------------------------------
  // Comparison bookkeeping; 4-state compare so X/Z outputs are caught.
  // ------------------------------------------------------------------------
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t",
               name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [15:0] s0,
                               input logic [15:0] s1);
    pcmIf.valid = v;
    pcmIf.pcm   = {s1, s0};
  endtask

  // Advance to just after the next rising edge(s).
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ------------------------------------------------------------------------
  // Model helpers.
  // A signed sample maps linearly onto 0..255 after offset binary.
  // A sigma-delta stream that starts each period from zero emits a one at
  // step c exactly when floor((c+1)*d/256) exceeds floor(c*d/256).
  // ------------------------------------------------------------------------
  function automatic int toDuty(input logic [15:0] s);
    int v;
    v = int'($signed(s));
    return (v + 32768) / 256;
  endfunction

  function automatic bit sdBit(input int d, input int c);
    return (((c + 1) * d) / PER - (c * d) / PER) != 0;
  endfunction

  // ------------------------------------------------------------------------
  // Period-level model, advanced on every rising edge from the inputs
  // presented before that edge.
  // ------------------------------------------------------------------------
  int       mCnt;
  int       mDuty   [NCH];
  int       mShadow [NCH];
  bit       mFull;
  bit       mMode;
  bit [NCH-1:0] expPwm;
  bit       expPs;
  bit       expUr;
  bit       modelLive = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mCnt      = 0;
      mFull     = 1'b0;
      mMode     = 1'b0;
      mDuty     = '{128, 128};
      mShadow   = '{128, 128};
      expPwm    = '0;
      expPs     = 1'b0;
      expUr     = 1'b0;
      modelLive = 1'b1;
    end else begin : advance
      bit xfer;
      bit bnd;
      xfer = (pcmIf.valid === 1'b1) && !mFull;
      bnd  = (mCnt == PER - 1);
      for (int k = 0; k < NCH; k++) begin
        expPwm[k] = mMode ? sdBit(mDuty[k], mCnt) : (mCnt < mDuty[k]);
      end
      expPs = (mCnt == 0);
      expUr = bnd && !mFull;
      if (bnd) begin
        if (mFull) begin
          mDuty = mShadow;
          mFull = 1'b0;
        end
        mMode = mode;
      end
      if (xfer) begin
        for (int k = 0; k < NCH; k++) begin
          mShadow[k] = toDuty(pcmIf.pcm[k*DW +: DW]);
        end
        mFull = 1'b1;
      end
      mCnt = (mCnt + 1) % PER;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (modelLive) begin
      for (int k = 0; k < NCH; k++) begin
        checkOutput($sformatf("pwm_out[%0d]", k), pwmW[k], expPwm[k]);
      end
      checkOutput("period_start", psW, expPs);
      checkOutput("underrun", urW, expUr);
      checkOutput("pcm_ready", pcmIf.ready, (!rst && !mFull));
    end
  end

  // ------------------------------------------------------------------------
  // Measure one full period starting at the next period_start pulse (the
  // current cycle counts if it is one). Leaves the caller in the cycle of
  // the following period_start.
  // ------------------------------------------------------------------------
  task automatic measurePeriod(output int o0, output int o1, output int urs,
                               output int maxRun0);
    int guard;
    int run;
    guard   = 0;
    run     = 0;
    o0      = 0;
    o1      = 0;
    urs     = 0;
    maxRun0 = 0;
    while (psW !== 1'b1 && guard < 2 * PER) begin
      tick(1);
      guard++;
    end
    if (guard >= 2 * PER) begin
      checkOutput("period_start_timeout", 0, 1);
    end
    for (int i = 0; i < PER; i++) begin
      if (pwmW[0] === 1'b1) begin
        o0++;
        run++;
        if (run > maxRun0) maxRun0 = run;
      end else begin
        run = 0;
      end
      if (pwmW[1] === 1'b1) o1++;
      if (urW === 1'b1) urs++;
      tick(1);
    end
  endtask

  // ------------------------------------------------------------------------
  // Directed stimulus
  // ------------------------------------------------------------------------
  initial begin
    int o0, o1, urs, mr;
    int n, xfers, urCnt;
    bit rdy;

    rst  = 1'b1;
    mode = 1'b0;
    applyStimulus(1'b0, 16'h0000, 16'h0000);

    // Reset and idle: midscale silence, one underrun per period.
    tick(3);
    checkOutput("ready_in_reset", pcmIf.ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", pcmIf.ready, 1'b1);
    checkOutput("pwm_after_reset", pwmW, 2'b00);
    for (int p = 0; p < 2; p++) begin
      measurePeriod(o0, o1, urs, mr);
      checkOutput("idle_ch0_high", o0, 128);
      checkOutput("idle_ch1_high", o1, 128);
      checkOutput("idle_underruns", urs, 1);
    end

    // Full-scale samples mid-period: applied at the next boundary only.
    tick(100);
    applyStimulus(1'b1, 16'h7FFF, 16'h8000);
    tick(1);
    applyStimulus(1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    checkOutput("ready_after_transfer", pcmIf.ready, 1'b0);
    measurePeriod(o0, o1, urs, mr);
    checkOutput("full_ch0_high", o0, 255);
    checkOutput("full_ch1_high", o1, 0);

    // Continuous valid: one transfer per period, no underruns.
    n     = 1;
    xfers = 0;
    urCnt = 0;
    applyStimulus(1'b1, 16'h1000, 16'hF000);
    for (int i = 0; i < 3 * PER; i++) begin
      rdy = pcmIf.ready;
      tick(1);
      if (urW === 1'b1) urCnt++;
      if (rdy) begin
        xfers++;
        n++;
        applyStimulus(1'b1, 16'(n * 4096), 16'(-n * 4096));
      end
    end
    applyStimulus(1'b0, 16'h0000, 16'h0000);
    checkOutput("stream_transfers", xfers, 4);
    checkOutput("stream_underruns", urCnt, 0);
    // Current period runs the third sample (0x3000 / 0xD000).
    measurePeriod(o0, o1, urs, mr);
    checkOutput("stream_ch0_high", o0, 176);
    checkOutput("stream_ch1_high", o1, 80);
    checkOutput("stream_end_underrun", urs, 0);

    // Valid in the boundary cycle with an empty shadow.
    tick(PER - 2);
    applyStimulus(1'b1, 16'h2000, 16'hE000);
    tick(1);
    applyStimulus(1'b0, 16'h0000, 16'h0000);
    checkOutput("boundary_underrun", urW, 1'b1);
    @(negedge clk);
    checkOutput("boundary_ready", pcmIf.ready, 1'b0);
    measurePeriod(o0, o1, urs, mr);
    checkOutput("boundary_old_ch0", o0, 192);
    checkOutput("boundary_old_ch1", o1, 64);
    measurePeriod(o0, o1, urs, mr);
    checkOutput("boundary_new_ch0", o0, 160);
    checkOutput("boundary_new_ch1", o1, 96);

    // Sigma-delta with duty 64 on ch0 and 192 on ch1.
    tick(50);
    mode = 1'b1;
    applyStimulus(1'b1, 16'hC000, 16'h4000);
    tick(1);
    applyStimulus(1'b0, 16'h0000, 16'h0000);
    measurePeriod(o0, o1, urs, mr);
    checkOutput("sd_ch0_ones", o0, 64);
    checkOutput("sd_ch1_ones", o1, 192);
    checkOutput("sd_ch0_maxrun", mr, 1);
    tick(100);
    mode = 1'b0;
    tick(50);
    mode = 1'b1;
    measurePeriod(o0, o1, urs, mr);
    checkOutput("sd_toggle_ch0_ones", o0, 64);
    checkOutput("sd_toggle_ch0_maxrun", mr, 1);
    mode = 1'b0;
    measurePeriod(o0, o1, urs, mr);
    checkOutput("sd_last_period_maxrun", mr, 1);
    measurePeriod(o0, o1, urs, mr);
    checkOutput("pwm_back_ch0_high", o0, 64);
    checkOutput("pwm_back_ch0_maxrun", mr, 64);

    // Reset mid-period with a pending sample: sample is lost.
    tick(80);
    applyStimulus(1'b1, 16'h7FFF, 16'h7FFF);
    tick(1);
    applyStimulus(1'b0, 16'h0000, 16'h0000);
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_pwm", pwmW, 2'b00);
    checkOutput("rst_mid_ready", pcmIf.ready, 1'b1);
    measurePeriod(o0, o1, urs, mr);
    checkOutput("rst_mid_ch0_high", o0, 128);
    checkOutput("rst_mid_ch1_high", o1, 128);
    checkOutput("rst_mid_underruns", urs, 1);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
